// File: rtl/nibble_packer_if.sv
// Nibble-in / byte-out handshake bundle for nibble_packer.
// master = upstream/downstream environment, slave = the packer itself.
interface nibble_packer_if;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_partial;

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid, out_partial
    );

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid, out_partial
    );
endinterface

// File: rtl/nibble_packer.sv
// Packs pairs of 4-bit nibbles into bytes; flush emits a zero-padded partial byte.
// Output register is a one-deep slot that may load in the same cycle it drains.
module nibble_packer #(
    parameter bit          HI_FIRST = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    nibble_packer_if.slave   bus,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic {EMPTY, HALF} state_e;

    state_e           state_q, state_d;
    logic [3:0]       hold_q, hold_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             partial_q, partial_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic slot_free;
    logic in_xfer;
    logic out_xfer;

    // Place the first nibble of a pair in the high or low half of the byte.
    function automatic logic [7:0] pack(input logic [3:0] first, input logic [3:0] second);
        return HI_FIRST ? {first, second} : {second, first};
    endfunction

    assign slot_free    = !valid_q || bus.out_ready;
    assign bus.in_ready = (state_q == EMPTY) || slot_free;
    assign in_xfer      = bus.in_valid && bus.in_ready;
    assign out_xfer     = valid_q && bus.out_ready;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        data_d    = data_q;
        valid_d   = out_xfer ? 1'b0 : valid_q;
        partial_d = out_xfer ? 1'b0 : partial_q;
        count_d   = out_xfer ? count_q + CNT_W'(1) : count_q;

        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    hold_d  = bus.in_data;
                    state_d = HALF;
                end
            end
            HALF: begin
                // A completing nibble wins over flush; the flush is simply consumed.
                if (in_xfer) begin
                    data_d    = pack(hold_q, bus.in_data);
                    valid_d   = 1'b1;
                    partial_d = 1'b0;
                    state_d   = EMPTY;
                end else if (bus.flush && slot_free) begin
                    data_d    = pack(hold_q, 4'h0);
                    valid_d   = 1'b1;
                    partial_d = 1'b1;
                    state_d   = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            hold_q    <= 4'h0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            partial_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            partial_q <= partial_d;
            count_q   <= count_d;
        end
    end

    assign bus.out_data    = data_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_partial = partial_q;
    assign byte_count      = count_q;

endmodule
